ram_burst_ctrl: RTL

- Burst front-end that sits directly upstream of the single-port RAM (`memory`). It drives that RAM's rd/wr/addr/din and consumes its dout.
- Accepts one burst command at a time: a start address, a length, and a direction.
- For write bursts it streams write data into the RAM with a valid/ready handshake.
- For read bursts it returns read data as a valid/ready stream, absorbing the RAM's 1-cycle registered read latency and any downstream backpressure.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_burst_ctrl_if.sv | 35 +++
 rtl/ram_rd_skid.sv | 51 +++++
 rtl/ram_burst_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the burst front-end and the single-port RAM it drives.
package ram_pkg;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 8;
  localparam int RAM_LEN_W  = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-data and read-data streams between a burst client and ram_burst_ctrl.
// Every stream transfers exactly on a clock edge where valid && ready are both high;
// a source holds valid and its payload stable until that edge, and ready may depend on state only.
interface ram_burst_ctrl_if #(
  parameter int ADDR_W = ram_pkg::RAM_ADDR_W,
  parameter int DATA_W = ram_pkg::RAM_DATA_W,
  parameter int LEN_W  = ram_pkg::RAM_LEN_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;

  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last
  );

endinterface

// File: rtl/ram_rd_skid.sv
// Two-entry FIFO holding {last, data} read beats; the head entry sits in e0.
module ram_rd_skid #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;

  assign head  = e0;
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        // Simultaneous push/pop keeps the count; the new beat lands behind the survivor.
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst front-end for the single-port RAM: streams write bursts in, and streams read
// bursts out through a 2-entry skid buffer that absorbs RAM latency and backpressure.
module ram_burst_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int LEN_W  = RAM_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  ram_burst_ctrl_if.slave   bus,
  output logic              busy,
  output logic [1:0]        state_dbg,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [LEN_W:0]    BEAT_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    beat_cnt;
  logic [LEN_W:0]    issued;
  logic [LEN_W:0]    len_total;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic              last_beat;
  logic              last_issue;
  logic [2:0]        occ;

  assign len_total  = {1'b0, len_q} + BEAT_ONE;
  assign last_beat  = (beat_cnt + BEAT_ONE) == len_total;
  assign last_issue = (issued + BEAT_ONE) == len_total;

  assign bus.rdata_valid       = fifo_count != 2'd0;
  assign {bus.rdata_last, bus.rdata} = fifo_head;
  assign pop = bus.rdata_valid && bus.rdata_ready;

  // Occupancy the buffer will have after this edge if no new read is issued.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

  assign bus.cmd_ready   = state == ST_IDLE;
  assign bus.wdata_ready = state == ST_WRITE;
  assign ram_wr    = (state == ST_WRITE) && bus.wdata_valid;
  assign ram_rd    = (state == ST_READ) && (issued < len_total) && (occ < 3'd2);
  assign ram_addr  = cur_addr;
  assign ram_din   = (state == ST_WRITE) ? bus.wdata : '0;
  assign busy      = state != ST_IDLE;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur_addr      <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= ram_rd;
      inflight_last <= ram_rd && last_issue;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            cur_addr <= bus.cmd_addr;
            len_q    <= bus.cmd_len;
            beat_cnt <= '0;
            issued   <= '0;
            state    <= bus.cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (ram_wr) begin
            cur_addr <= cur_addr + ADDR_ONE;
            beat_cnt <= beat_cnt + BEAT_ONE;
            if (last_beat) state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (ram_rd) begin
            cur_addr <= cur_addr + ADDR_ONE;
            issued   <= issued + BEAT_ONE;
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((fifo_count == 2'd0) && !inflight) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ram_rd_skid #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, ram_dout}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
